// File: rtl/timer_ctrl.sv
// timer_ctrl: programmable period timer controller.
//   Latches period/prescale/mode on an accepted start, gates a main up-counter
//   through a prescaler, and emits a registered one-cycle tick at terminal
//   count. Supports one-shot (ends in DONE) and auto-reload operation, with
//   pause and stop control. Priority each cycle: stop > pause > start.
//
// Ports:
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   start        start request (accepted in IDLE/DONE when stop=0)
//   stop         abort request; returns to IDLE, clears count/prescaler
//   pause        level; holds counting while high (RUN/PAUSE only)
//   period       terminal count value, latched on accepted start
//   presc        prescale divisor minus one, latched on accepted start
//   auto_reload  1 = periodic, 0 = one-shot, latched on accepted start
//   count        current main count (registered)
//   tick         one-cycle terminal-count pulse (registered)
//   busy         high in RUN or PAUSE
//   done         high in DONE
//   state        IDLE=0, RUN=1, PAUSE=2, DONE=3
//   tick_cnt     (TIMER_CTRL_TICK_CNT_EN only) saturating tick counter,
//                cleared on every accepted start
//
// Optional feature macro: TIMER_CTRL_TICK_CNT_EN
module timer_ctrl #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic [WIDTH-1:0]   period,
  input  logic [PRESC_W-1:0] presc,
  input  logic               auto_reload,
  output logic [WIDTH-1:0]   count,
  output logic               tick,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state
`ifdef TIMER_CTRL_TICK_CNT_EN
  ,
  output logic [7:0]         tick_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_count, w_count_nxt;
  logic [PRESC_W-1:0]   r_psc, w_psc_nxt;
  logic                 r_tick, w_tick_nxt;
  logic [WIDTH-1:0]     r_period_l, w_period_nxt;
  logic [PRESC_W-1:0]   r_presc_l, w_presc_nxt;
  logic                 r_auto_l, w_auto_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_psc      <= '0;
      r_tick     <= 1'b0;
      r_period_l <= '0;
      r_presc_l  <= '0;
      r_auto_l   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_psc      <= w_psc_nxt;
      r_tick     <= w_tick_nxt;
      r_period_l <= w_period_nxt;
      r_presc_l  <= w_presc_nxt;
      r_auto_l   <= w_auto_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_psc_nxt    = r_psc;
    w_tick_nxt   = 1'b0;
    w_period_nxt = r_period_l;
    w_presc_nxt  = r_presc_l;
    w_auto_nxt   = r_auto_l;
    if (stop) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = '0;
      w_psc_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            w_period_nxt = period;
            w_presc_nxt  = presc;
            w_auto_nxt   = auto_reload;
            w_count_nxt  = '0;
            w_psc_nxt    = '0;
            w_state_nxt  = ST_RUN;
          end
        end
        ST_RUN, ST_PAUSE: begin
          if (pause) begin
            w_state_nxt = ST_PAUSE;
          end else begin
            // Leaving PAUSE takes a step on the same edge, so a pause held for
            // N cycles delays the next tick by exactly N clocks.
            w_state_nxt = ST_RUN;
            if (r_psc == r_presc_l) begin
              w_psc_nxt = '0;
              if (r_count == r_period_l) begin
                w_tick_nxt  = 1'b1;
                w_count_nxt = '0;
                if (!r_auto_l) w_state_nxt = ST_DONE;
              end else begin
                w_count_nxt = r_count + 1'b1;
              end
            end else begin
              w_psc_nxt = r_psc + 1'b1;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign count = r_count;
  assign tick  = r_tick;
  assign busy  = (r_state == ST_RUN) || (r_state == ST_PAUSE);
  assign done  = (r_state == ST_DONE);
  assign state = r_state;

`ifdef TIMER_CTRL_TICK_CNT_EN
  logic       w_start_acc;
  logic [7:0] r_tick_cnt;

  assign w_start_acc = start && !stop && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tick_cnt <= '0;
    end else if (w_start_acc) begin
      r_tick_cnt <= '0;
    end else if (w_tick_nxt && (r_tick_cnt != 8'hFF)) begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  assign tick_cnt = r_tick_cnt;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed scenarios plus randomized
// stimulus checked against an elapsed-active-cycle model of the timer.
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0, auto_reload = 1'b0;
  logic [7:0] period = '0;
  logic [3:0] presc = '0;
  logic [7:0] count;
  logic       tick, busy, done;
  logic [1:0] state;
`ifdef TIMER_CTRL_TICK_CNT_EN
  logic [7:0] tick_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Model: m_n counts non-paused cycles since start (mod full tick period).
  int m_st = 0, m_n = 0, m_P = 0, m_S = 0, m_A = 0, m_tcnt = 0;
  bit m_tick = 1'b0;

  timer_ctrl #(.WIDTH(8), .PRESC_W(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .pause(pause),
    .period(period), .presc(presc), .auto_reload(auto_reload),
    .count(count), .tick(tick), .busy(busy), .done(done), .state(state)
`ifdef TIMER_CTRL_TICK_CNT_EN
    , .tick_cnt(tick_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish (got running, need finished)");
    $fatal(1);
  end

  function automatic int m_count();
    if (m_st == 1 || m_st == 2) return (m_n / (m_S + 1)) % (m_P + 1);
    return 0;
  endfunction

  task automatic model_reset();
    m_st = 0; m_n = 0; m_P = 0; m_S = 0; m_A = 0; m_tcnt = 0; m_tick = 1'b0;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then
  // move to a point 1 time unit after the edge for sampling.
  task automatic cycle();
    @(posedge clk);
    if (!rstn) begin
      model_reset();
    end else begin
      m_tick = 1'b0;
      if (stop) begin
        m_st = 0; m_n = 0;
      end else if ((m_st == 0 || m_st == 3) && start) begin
        m_P = period; m_S = presc; m_A = auto_reload; m_n = 0; m_st = 1; m_tcnt = 0;
      end else if (m_st == 1 || m_st == 2) begin
        if (pause) m_st = 2;
        else begin
          m_st = 1;
          m_n++;
          if (m_n == (m_P + 1) * (m_S + 1)) begin
            m_n = 0; m_tick = 1'b1;
            if (m_tcnt < 255) m_tcnt++;
            if (m_A == 0) m_st = 3;
          end
        end
      end
    end
    #1;
  endtask

  task automatic do_start(input logic [7:0] p, input logic [3:0] s, input logic a);
    period = p; presc = s; auto_reload = a; start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic go_idle();
    stop = 1'b1; cycle(); stop = 1'b0;
  endtask

  task automatic test_reset();
    #1 rstn = 1'b0;
    model_reset();
    #2;
    n_cmp++;
    if ({count, tick, busy, done, state} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h need 0", {count, tick, busy, done, state});
    end
    rstn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_cmp++;
      if (state !== 2'd0 || count !== 8'd0) begin
        n_bad++;
        $display("FAIL reset_idle_hold: got state=%0d count=%0d need 0/0", state, count);
      end
    end
  endtask

  task automatic test_oneshot();
    do_start(8'd3, 4'd0, 1'b0);
    n_cmp++;
    if (state !== 2'd1 || count !== 8'd0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL oneshot_start: got state=%0d count=%0d busy=%b need 1/0/1", state, count, busy);
    end
    for (int i = 1; i <= 3; i++) begin
      cycle();
      n_cmp++;
      if (count !== 8'(i) || tick !== 1'b0 || state !== 2'd1) begin
        n_bad++;
        $display("FAIL oneshot_count: got count=%0d tick=%b state=%0d need %0d/0/1", count, tick, state, i);
      end
    end
    cycle();
    n_cmp++;
    if ({count, tick, busy, done, state} !== {8'd0, 1'b1, 1'b0, 1'b1, 2'd3}) begin
      n_bad++;
      $display("FAIL oneshot_term: got count=%0d tick=%b busy=%b done=%b state=%0d need 0/1/0/1/3",
               count, tick, busy, done, state);
    end
    cycle();
    n_cmp++;
    if (tick !== 1'b0 || state !== 2'd3 || count !== 8'd0) begin
      n_bad++;
      $display("FAIL oneshot_done_hold: got tick=%b state=%0d count=%0d need 0/3/0", tick, state, count);
    end
  endtask

  task automatic test_periodic();
    do_start(8'd2, 4'd1, 1'b1);
    for (int k = 1; k <= 30; k++) begin
      cycle();
      n_cmp++;
      if ({tick, busy, state} !== {(k % 6 == 0), 1'b1, 2'd1}) begin
        n_bad++;
        $display("FAIL periodic_k%0d: got tick=%b busy=%b state=%0d need %b/1/1", k, tick, busy, state, (k % 6 == 0));
      end
    end
    go_idle();
  endtask

  task automatic test_pause();
    do_start(8'd5, 4'd0, 1'b1);
    cycle(); cycle();
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if (state !== 2'd2 || count !== 8'd2 || tick !== 1'b0) begin
        n_bad++;
        $display("FAIL pause_hold: got state=%0d count=%0d tick=%b need 2/2/0", state, count, tick);
      end
    end
    pause = 1'b0;
    for (int k = 6; k <= 9; k++) begin
      cycle();
      n_cmp++;
      if (tick !== (k == 9) || count !== 8'((k - 3) % 6)) begin
        n_bad++;
        $display("FAIL pause_resume_k%0d: got tick=%b count=%0d need %b/%0d", k, tick, count, (k == 9), (k - 3) % 6);
      end
    end
    go_idle();
  endtask

  task automatic test_stop();
    do_start(8'd4, 4'd0, 1'b1);
    repeat (4) cycle();
    n_cmp++;
    if (count !== 8'd4) begin
      n_bad++;
      $display("FAIL stop_pre: got count=%0d need 4", count);
    end
    stop = 1'b1; pause = 1'b1; start = 1'b1;
    cycle();
    n_cmp++;
    if ({count, tick, busy, state} !== 11'd0) begin
      n_bad++;
      $display("FAIL stop_combo: got count=%0d tick=%b busy=%b state=%0d need 0/0/0/0", count, tick, busy, state);
    end
    stop = 1'b0; pause = 1'b0; start = 1'b0;
    cycle();
    n_cmp++;
    if (state !== 2'd0 || tick !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_after: got state=%0d tick=%b need 0/0", state, tick);
    end
  endtask

  task automatic test_async_reset();
    do_start(8'd9, 4'd0, 1'b1);
    repeat (3) cycle();
    n_cmp++;
    if (count !== 8'd3) begin
      n_bad++;
      $display("FAIL areset_pre: got count=%0d need 3", count);
    end
    #2 rstn = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({count, tick, busy, done, state} !== 13'd0) begin
      n_bad++;
      $display("FAIL areset_immediate: got %h need 0", {count, tick, busy, done, state});
    end
`ifdef TIMER_CTRL_TICK_CNT_EN
    n_cmp++;
    if (tick_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL areset_tick_cnt: got %0d need 0", tick_cnt);
    end
`endif
    #2 rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if (state !== 2'd0 || count !== 8'd0) begin
        n_bad++;
        $display("FAIL areset_idle: got state=%0d count=%0d need 0/0", state, count);
      end
    end
  endtask

  task automatic test_edge_relatch();
    do_start(8'd0, 4'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) period = 8'd7;
      cycle();
      n_cmp++;
      if (tick !== 1'b1 || count !== 8'd0 || state !== 2'd1) begin
        n_bad++;
        $display("FAIL edge_every_cycle_%0d: got tick=%b count=%0d state=%0d need 1/0/1", i, tick, count, state);
      end
    end
    go_idle();
    do_start(8'd7, 4'd0, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      cycle();
      n_cmp++;
      if (tick !== (k % 8 == 0)) begin
        n_bad++;
        $display("FAIL relatch_k%0d: got tick=%b need %b", k, tick, (k % 8 == 0));
      end
    end
    go_idle();
  endtask

`ifdef TIMER_CTRL_TICK_CNT_EN
  task automatic test_tick_cnt();
    do_start(8'd0, 4'd0, 1'b1);
    repeat (300) cycle();
    n_cmp++;
    if (tick_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL tick_cnt_sat: got %0d need 255", tick_cnt);
    end
    go_idle();
    n_cmp++;
    if (tick_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL tick_cnt_idle_hold: got %0d need 255", tick_cnt);
    end
    do_start(8'd0, 4'd0, 1'b1);
    n_cmp++;
    if (tick_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL tick_cnt_clear: got %0d need 0", tick_cnt);
    end
    cycle();
    n_cmp++;
    if (tick_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL tick_cnt_inc: got %0d need 1", tick_cnt);
    end
    go_idle();
  endtask
`endif

  task automatic test_random();
    logic [12:0] exp_v;
    for (int i = 0; i < 1500; i++) begin
      start       = ($urandom % 6 == 0);
      stop        = ($urandom % 50 == 0);
      pause       = ($urandom % 7 == 0);
      auto_reload = ($urandom % 2 == 0);
      period      = ($urandom % 12 == 0) ? 8'($urandom) : 8'($urandom_range(5, 0));
      presc       = 4'($urandom_range(2, 0));
      cycle();
      exp_v = {8'(m_count()), m_tick, (m_st == 1 || m_st == 2), (m_st == 3), 2'(m_st)};
      n_cmp++;
      if ({count, tick, busy, done, state} !== exp_v) begin
        n_bad++;
        $display("FAIL random_%0d: got count=%0d tick=%b busy=%b done=%b state=%0d need count=%0d tick=%b busy=%b done=%b state=%0d",
                 i, count, tick, busy, done, state,
                 exp_v[12:5], exp_v[4], exp_v[3], exp_v[2], exp_v[1:0]);
      end
`ifdef TIMER_CTRL_TICK_CNT_EN
      n_cmp++;
      if (tick_cnt !== 8'(m_tcnt)) begin
        n_bad++;
        $display("FAIL random_tick_cnt_%0d: got %0d need %0d", i, tick_cnt, m_tcnt);
      end
`endif
    end
    start = 1'b0; stop = 1'b0; pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_stop();
    test_async_reset();
    test_edge_relatch();
`ifdef TIMER_CTRL_TICK_CNT_EN
    test_tick_cnt();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
